// File: rtl/img_row_pass_ctrl.sv
// img_row_pass_ctrl: sequences one clamped 3-row window pass from the source buffer through the row kernel into the destination buffer
module img_row_pass_ctrl #(
  parameter int ROWS = 480,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 640
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] src_raddr,
  input  logic [DATA_W-1:0] src_rdata,
  output logic              dst_we,
  output logic [ADDR_W-1:0] dst_waddr,
  output logic [DATA_W-1:0] dst_wdata,
  output logic              k_valid,
  input  logic              k_ready,
  output logic [ADDR_W-1:0] k_row,
  output logic [DATA_W-1:0] k_top,
  output logic [DATA_W-1:0] k_mid,
  output logic [DATA_W-1:0] k_bot,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [DATA_W-1:0] r_data
);
  typedef enum logic [3:0] {IDLE, RD0, RD1, CAP, ISSUE, WAIT, NEXT, LOAD, FLUSH, DONE} state_t;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(ROWS - 1);
  state_t state, nxt;
  logic [ADDR_W-1:0] row;
  logic [DATA_W-1:0] top, mid, bot;
  logic [ADDR_W:0] row2;
  logic last;
  // one extra bit so row+2 clamps before it can wrap
  assign row2 = {1'b0, row} + (ADDR_W+1)'(2);
  assign last = {1'b0, row} == LAST;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? RD0 : IDLE;
      RD0:     nxt = RD1;
      RD1:     nxt = CAP;
      CAP:     nxt = ISSUE;
      ISSUE:   nxt = k_ready ? WAIT : ISSUE;
      WAIT:    nxt = r_valid ? (last ? FLUSH : NEXT) : WAIT;
      NEXT:    nxt = LOAD;
      LOAD:    nxt = ISSUE;
      FLUSH:   nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE && state != DONE;
    done = state == DONE;
    k_valid = state == ISSUE;
    r_ready = state == WAIT;
    src_raddr = state == RD1 ? ADDR_W'(LAST != '0) :
                state == NEXT ? (row2 > LAST ? LAST[ADDR_W-1:0] : row2[ADDR_W-1:0]) : '0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      row <= '0;
      top <= '0;
      mid <= '0;
      bot <= '0;
      dst_we <= 1'b0;
      dst_waddr <= '0;
      dst_wdata <= '0;
    end else begin
      dst_we <= state == WAIT && r_valid;
      if (state == WAIT && r_valid) begin
        dst_waddr <= row;
        dst_wdata <= r_data;
      end
      if (state == IDLE && start) row <= '0;
      if (state == RD1) begin
        top <= src_rdata;
        mid <= src_rdata;
      end
      if (state == CAP || state == LOAD) bot <= src_rdata;
      if (state == NEXT) begin
        top <= mid;
        mid <= bot;
        row <= row + ADDR_W'(1);
      end
    end
  assign k_row = row;
  assign k_top = top;
  assign k_mid = mid;
  assign k_bot = bot;
endmodule

// File: tb/tb_img_row_pass_ctrl.sv
// tb_img_row_pass_ctrl: randomized and directed passes for ROWS=4, 1 and 480 against a frame-level reference model
module tb_img_row_pass_ctrl;
  localparam int DW = 640;
  logic clk = 1'b0;
  int errors = 0;
  int checks = 0;
  int fin = 0;
  always #20 clk = ~clk;

  task automatic chk(input bit ok, input string nm, input logic [DW-1:0] a, input logic [DW-1:0] e);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, a, e);
    end
  endtask

  function automatic logic [DW-1:0] pat(int i);
    logic [7:0] b;
    b = 8'(i + 1);
    return {(DW/8){b}};
  endfunction

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // kernel: echo the middle row, or a mix of all three rows
  function automatic logic [DW-1:0] kf(logic [DW-1:0] t, logic [DW-1:0] m, logic [DW-1:0] b, bit e);
    return e ? m : (t ^ {m[DW-2:0], m[DW-1]} ^ ~b);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int R = g == 0 ? 4 : g == 1 ? 1 : 480;
    logic rst = 1'b1, start = 1'b0, busy, done, dst_we, k_valid, k_ready = 1'b0, r_valid = 1'b0, r_ready;
    logic [8:0] src_raddr, dst_waddr, k_row;
    logic [DW-1:0] src_rdata, dst_wdata, k_top, k_mid, k_bot, r_data = '0;
    logic [DW-1:0] mem [512];
    logic [DW-1:0] dmem [512];
    logic [DW-1:0] wt [4], wm [4], wb [4];
    int mode = 0, cyc = 0, st_cyc = 0, row = 0, kst = 0, rwc = 0, ndone = 0, wcnt = 0;
    bit echo = 1'b1, in_pass = 1'b0, exp_we = 1'b0, exp_done = 1'b0, pend = 1'b0, rchk = 1'b0, live = 1'b0;
    bit hk, hr, n_done;
    logic [8:0] exp_wa = '0;
    logic [DW-1:0] exp_wd = '0, pres = '0;

    img_row_pass_ctrl #(.ROWS(R), .ADDR_W(9), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .src_raddr(src_raddr), .src_rdata(src_rdata),
      .dst_we(dst_we), .dst_waddr(dst_waddr), .dst_wdata(dst_wdata),
      .k_valid(k_valid), .k_ready(k_ready), .k_row(k_row),
      .k_top(k_top), .k_mid(k_mid), .k_bot(k_bot),
      .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data)
    );

    always @(posedge clk) src_rdata <= mem[src_raddr];

    function automatic logic [DW-1:0] mrow(int r);
      return mem[r < 0 ? 0 : r > R - 1 ? R - 1 : r];
    endfunction

    always @(negedge clk) begin
      cyc++;
      if (live) begin
        if (rchk) begin
          chk({busy, done, dst_we, k_valid, r_ready} == 5'b0, "rst_ctl", DW'({busy, done, dst_we, k_valid, r_ready}), '0);
          chk({src_raddr, k_row, dst_waddr} == 27'b0, "rst_addr", DW'({src_raddr, k_row, dst_waddr}), '0);
          chk((k_top | k_mid | k_bot | dst_wdata) == '0, "rst_data", k_top | k_mid | k_bot | dst_wdata, '0);
        end
        chk(busy == (in_pass && !exp_done), "busy", DW'(busy), DW'(in_pass && !exp_done));
        chk(done == exp_done, "done", DW'(done), DW'(exp_done));
        chk(dst_we == exp_we, "dst_we", DW'(dst_we), DW'(exp_we));
        chk(!(k_valid && r_ready), "excl", DW'({k_valid, r_ready}), '0);
        if (!in_pass) chk(!(k_valid || r_ready), "idle_hs", DW'({k_valid, r_ready}), '0);
        if (exp_we) begin
          wcnt++;
          dmem[dst_waddr] = dst_wdata;
          chk(dst_waddr == exp_wa, "dst_waddr", DW'(dst_waddr), DW'(exp_wa));
          chk(dst_wdata == exp_wd, "dst_wdata", dst_wdata, exp_wd);
          if (mode == 0) chk(cyc - st_cyc == 6 + 4 * int'(exp_wa), "we_time", DW'(cyc - st_cyc), DW'(6 + 4 * int'(exp_wa)));
        end
        if (exp_done) begin
          ndone++;
          if (mode == 0) chk(cyc - st_cyc == 4 * R + 3, "done_time", DW'(cyc - st_cyc), DW'(4 * R + 3));
        end
        if (k_valid) begin
          chk(k_row == 9'(row), "k_row", DW'(k_row), DW'(row));
          chk(k_top == mrow(row - 1), "k_top", k_top, mrow(row - 1));
          chk(k_mid == mrow(row), "k_mid", k_mid, mrow(row));
          chk(k_bot == mrow(row + 1), "k_bot", k_bot, mrow(row + 1));
        end
      end
      k_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : !(row == 1 && kst < 5);
      r_valid = pend && !rst && (mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : !(row == 1 && rwc < 7));
      r_data = r_valid ? pres : rnd();
      hk = k_valid && k_ready && !rst;
      hr = r_valid && r_ready;
      if (k_valid && !k_ready) kst++;
      if (r_ready && !r_valid) rwc++;
      rchk = 1'b0;
      if (rst) begin
        in_pass = 1'b0;
        exp_we = 1'b0;
        exp_done = 1'b0;
        pend = 1'b0;
        rchk = 1'b1;
        live = 1'b1;
      end else begin
        n_done = exp_we && exp_wa == 9'(R - 1);
        if (exp_done) in_pass = 1'b0;
        else if (!in_pass && start) begin
          in_pass = 1'b1;
          row = 0;
          st_cyc = cyc;
          kst = 0;
          rwc = 0;
        end
        if (hk) begin
          pend = 1'b1;
          pres = kf(k_top, k_mid, k_bot, echo);
          if (row < 4) begin
            wt[row] = k_top;
            wm[row] = k_mid;
            wb[row] = k_bot;
          end
        end
        exp_we = hr;
        if (hr) begin
          exp_wa = 9'(row);
          exp_wd = kf(mrow(row - 1), mrow(row), mrow(row + 1), echo);
          pend = 1'b0;
          row++;
          kst = 0;
          rwc = 0;
        end
        exp_done = n_done;
      end
    end

    task automatic tick();
      @(posedge clk);
      #1;
    endtask

    task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
    endtask

    task automatic wait_done(int n0);
      for (int i = 0; i < 40 * R + 200 && ndone == n0; i++) tick();
      chk(ndone != n0, "pass_timeout", DW'(ndone), DW'(n0 + 1));
    endtask

    task automatic run_pass(int m, bit e);
      int n0;
      n0 = ndone;
      mode = m;
      echo = e;
      wcnt = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(n0);
    endtask

    if (g == 0) begin : s
      initial begin
        int n0;
        for (int i = 0; i < 512; i++) mem[i] = i < R ? pat(i) : '0;
        tick();
        do_reset();
        run_pass(0, 1'b1);
        chk(wt[0] == pat(0) && wm[0] == pat(0), "win0_top_mid", wt[0] ^ wm[0], '0);
        chk(wb[0] == pat(1), "win0_bot", wb[0], pat(1));
        chk(wt[3] == pat(2) && wm[3] == pat(3) && wb[3] == pat(3), "win3", wt[3], pat(2));
        for (int i = 0; i < R; i++) chk(dmem[i] == pat(i), "dst_echo", dmem[i], pat(i));
        for (int i = 0; i < R; i++) dmem[i] = '0;
        run_pass(2, 1'b1);
        for (int i = 0; i < R; i++) chk(dmem[i] == pat(i), "dst_stall", dmem[i], pat(i));
        n0 = ndone;
        mode = 0;
        start = 1'b1;
        repeat (4 * R + 5) tick();
        start = 1'b0;
        for (int i = 0; i < 40 * R + 200 && ndone < n0 + 2; i++) tick();
        chk(ndone == n0 + 2, "held_start", DW'(ndone - n0), DW'(2));
        n0 = ndone;
        mode = 1;
        echo = 1'b0;
        for (int i = 0; i < 3000 && ndone < n0 + 6; i++) begin
          start = $urandom_range(0, 3) == 0;
          tick();
        end
        start = 1'b0;
        for (int i = 0; i < 40 * R + 200 && in_pass; i++) tick();
        chk(ndone >= n0 + 6, "rand_passes", DW'(ndone - n0), DW'(6));
        mode = 0;
        echo = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100 && !(r_ready && k_row == 9'd2); i++) tick();
        chk(r_ready && k_row == 9'd2, "reach_wait2", DW'({r_ready, k_row}), DW'({1'b1, 9'd2}));
        n0 = ndone;
        do_reset();
        repeat (10) tick();
        chk(ndone == n0, "no_done_after_rst", DW'(ndone), DW'(n0));
        for (int i = 0; i < R; i++) dmem[i] = '0;
        run_pass(0, 1'b1);
        for (int i = 0; i < R; i++) chk(dmem[i] == pat(i), "dst_after_rst", dmem[i], pat(i));
        fin++;
      end
    end else if (g == 1) begin : s
      initial begin
        for (int i = 0; i < 512; i++) mem[i] = i == 0 ? pat(0) : rnd();
        tick();
        do_reset();
        run_pass(0, 1'b1);
        chk(wt[0] == pat(0) && wm[0] == pat(0) && wb[0] == pat(0), "win_r1", wt[0] | wm[0] | wb[0], pat(0));
        chk(dmem[0] == pat(0), "dst_r1", dmem[0], pat(0));
        chk(wcnt == 1, "wcnt_r1", DW'(wcnt), DW'(1));
        run_pass(1, 1'b0);
        chk(wcnt == 1, "wcnt_r1_rand", DW'(wcnt), DW'(1));
        fin++;
      end
    end else begin : s
      initial begin
        for (int i = 0; i < 512; i++) mem[i] = rnd();
        tick();
        do_reset();
        run_pass(0, 1'b0);
        chk(wcnt == 480, "wcnt_480", DW'(wcnt), DW'(480));
        fin++;
      end
    end
  end

  initial begin
    for (int i = 0; i < 40000 && fin < 3; i++) @(posedge clk);
    chk(fin == 3, "sim_timeout", DW'(fin), DW'(3));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/img_row_pass_ctrl.md
Name: img_row_pass_ctrl

Overview:
Sequences one full-frame row-window pass over a 512x640 image buffer for the image coprocessor. It reads source rows over the buffer's registered read port (1-cycle latency) and holds a clamped 3-row window (top/mid/bot). It presents the window to a row kernel over a valid/ready handshake and writes each returned result row into the destination buffer's write port. It sits between the CPU-side coprocessor command register (start/done) and the source/destination image buffers.

Parameters:
ROWS, 480, number of image rows processed per pass (1..512)
ADDR_W, 9, row address width
DATA_W, 640, row width in bits (one bit per pixel)

Ports:
clk  input  1  system clock (25 MHz)
rst  input  1  synchronous active-high reset
start  input  1  begin pass; sampled only in IDLE
busy  output  1  high while a pass is in progress
done  output  1  one-cycle pulse when the last row is written
src_raddr  output  ADDR_W  source buffer read address; data returns next cycle
src_rdata  input  DATA_W  source buffer read data
dst_we  output  1  destination buffer write enable
dst_waddr  output  ADDR_W  destination write row
dst_wdata  output  DATA_W  destination write data
k_valid  output  1  window valid to kernel
k_ready  input  1  kernel accepts window
k_row  output  ADDR_W  row index of current window
k_top/k_mid/k_bot  output  DATA_W each  rows row-1, row, row+1 (clamped to 0..ROWS-1)
r_valid  input  1  kernel result valid
r_ready  output  1  controller accepts result
r_data  input  DATA_W  kernel result row

Behaviour:
- Reset (synchronous, any state): state=IDLE. All outputs are 0 the cycle after rst is sampled, including the window registers and row counter. A reset mid-pass abandons the pass with no further dst writes and no done pulse.
- The registered src_raddr value presented in cycle N yields src_rdata valid in cycle N+1.
- IDLE: busy=0. start=1 -> row=0, go RD0. start is ignored in every other state.
- RD0: src_raddr=0 -> RD1.
- RD1: src_raddr=min(1,ROWS-1). Capture src_rdata into top and mid (top clamps to row 0) -> CAP.
- CAP: capture src_rdata into bot -> ISSUE.
- ISSUE: k_valid=1, k_row=row. Window registers stay stable until k_valid&&k_ready, then -> WAIT.
- WAIT: r_ready=1. On r_valid: register dst_waddr=row and dst_wdata=r_data; dst_we=1 in the following cycle only. If row==ROWS-1 -> FLUSH, else -> NEXT.
- NEXT: src_raddr=min(row+2,ROWS-1). Shift top<=mid, mid<=bot, row<=row+1 -> LOAD.
- LOAD: bot<=src_rdata -> ISSUE.
- FLUSH: carries the last dst_we -> DONE.
- DONE: done=1 for exactly one cycle, busy=0 -> IDLE. A start sampled in this cycle is ignored; start is accepted from the next IDLE cycle.
- busy=1 in every state except IDLE and DONE.
- Edge clamp: row 0 has top=mid=row0. Row ROWS-1 has bot=mid=row ROWS-1. With ROWS=1, all three equal row 0.
- k_valid and r_ready are never high in the same cycle. At most one dst write per row, in ascending row order.
- Minimum timing, with k_ready=1 and r_valid high the first WAIT cycle (start sampled at cycle 0):
  - ISSUE for row r occurs at cycle 4+4r.
  - The last dst_we occurs at cycle 4*ROWS+2.
  - done occurs at cycle 4*ROWS+3.
- Row counter and addresses are ADDR_W wide. Computing row+2 must not wrap; clamp before truncation.

Test Plan:
1. ROWS=4, src row i = {DATA_W/8{8'(i+1)}}, kernel echoes k_mid -> dst rows 0..3 equal src. Row 0 window = (r0,r0,r1); row 3 window = (r2,r3,r3).
2. ROWS=1, single start -> k_top=k_mid=k_bot=src row 0. Exactly one dst_we at waddr 0, then done.
3. ROWS=4, k_ready held low 5 cycles and r_valid delayed 7 cycles on row 1 -> k_* and k_row stable throughout, no dst_we during the stalls, final dst contents identical to scenario 1.
4. start pulsed during RD1, WAIT and DONE -> ignored. Exactly one done pulse, and busy falls in the done cycle.
5. rst asserted while row=2 in WAIT -> next cycle busy=0, dst_we=0, k_valid=0, no done. A fresh start then completes a correct full frame.
6. ROWS=480, zero-stall echo kernel -> done exactly at cycle 1923 after the start cycle, 480 dst writes at addresses 0..479 in order.
